// File: rtl/pfl_cfg_sequencer.sv
// pfl_cfg_sequencer: selects a flash page, pulses PFL reconfigure and reset,
// then waits for CONF_DONE with bounded retries and a factory-page fallback.
module pfl_cfg_sequencer #(
    parameter int unsigned NUM_PAGES     = 3,
    parameter int unsigned PAGE_W        = 3,
    parameter int unsigned FACTORY_PAGE  = 0,
    parameter int unsigned RECONF_CYCLES = 24'hFFFFFF,
    parameter int unsigned RST_CYCLES    = 24'hFFFFFF,
    parameter int unsigned WAIT_CYCLES   = 28'hFFFFFFF,
    parameter int unsigned MAX_RETRY     = 1,
    parameter int unsigned CNT_W         = 28
) (
    input  logic              clkin_max_100,
    input  logic              sys_resetn,
    input  logic              max_csn,
    input  logic              mode_direct,
    input  logic [PAGE_W-1:0] page_sel,
    input  logic              fpga_conf_done,
    input  logic              fpga_statusn,
    output logic [PAGE_W-1:0] fpga_pgm,
    output logic              pfl_nreconfigure,
    output logic              pfl_nreset,
    output logic              busy,
    output logic              cfg_ok,
    output logic              cfg_err,
    output logic              fallback,
    output logic [2:0]        retry_cnt,
    output logic [PAGE_W-1:0] cur_page
);

    localparam logic [CNT_W-1:0]  RECONF_LAST = CNT_W'(RECONF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [PAGE_W-1:0] FACTORY     = PAGE_W'(FACTORY_PAGE);
    localparam logic [PAGE_W-1:0] LAST_PAGE   = PAGE_W'(NUM_PAGES - 1);
    localparam logic [2:0]        RETRY_LIMIT = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECONF,
        S_PFL_RST,
        S_WAIT,
        S_DECIDE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PAGE_W-1:0] pgm_nxt, cur_nxt, next_page;
    logic              nreconf_nxt, nrst_nxt, busy_nxt, ok_nxt, err_nxt, fb_nxt;
    logic [2:0]        retry_nxt;

    logic max_csn_m, max_csn_s, max_csn_d;
    logic fpga_conf_done_m, fpga_conf_done_s;
    logic fpga_statusn_m, fpga_statusn_s;
    logic req;

    // nSTATUS low is normal while the FPGA configures; kept synchronised for observation only
    logic unused_statusn;
    assign unused_statusn = fpga_statusn_s;

    // Two-flop synchronisers for the asynchronous inputs, plus request edge history
    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            max_csn_m        <= 1'b1;
            max_csn_s        <= 1'b1;
            max_csn_d        <= 1'b1;
            fpga_conf_done_m <= 1'b0;
            fpga_conf_done_s <= 1'b0;
            fpga_statusn_m   <= 1'b1;
            fpga_statusn_s   <= 1'b1;
        end else begin
            max_csn_m        <= max_csn;
            max_csn_s        <= max_csn_m;
            max_csn_d        <= max_csn_s;
            fpga_conf_done_m <= fpga_conf_done;
            fpga_conf_done_s <= fpga_conf_done_m;
            fpga_statusn_m   <= fpga_statusn;
            fpga_statusn_s   <= fpga_statusn_m;
        end
    end

    assign req       = max_csn_d & ~max_csn_s;
    assign next_page = (cur_page >= LAST_PAGE) ? '0 : cur_page + PAGE_W'(1);

    // State register and all registered outputs
    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state            <= S_IDLE;
            cnt              <= '0;
            fpga_pgm         <= FACTORY;
            pfl_nreconfigure <= 1'b1;
            pfl_nreset       <= 1'b1;
            busy             <= 1'b0;
            cfg_ok           <= 1'b0;
            cfg_err          <= 1'b0;
            fallback         <= 1'b0;
            retry_cnt        <= 3'd0;
            cur_page         <= FACTORY;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            fpga_pgm         <= pgm_nxt;
            pfl_nreconfigure <= nreconf_nxt;
            pfl_nreset       <= nrst_nxt;
            busy             <= busy_nxt;
            cfg_ok           <= ok_nxt;
            cfg_err          <= err_nxt;
            fallback         <= fb_nxt;
            retry_cnt        <= retry_nxt;
            cur_page         <= cur_nxt;
        end
    end

    // Next-state and next-output logic; the phase counter is cleared on every phase entry
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pgm_nxt     = fpga_pgm;
        nreconf_nxt = pfl_nreconfigure;
        nrst_nxt    = pfl_nreset;
        busy_nxt    = busy;
        ok_nxt      = cfg_ok;
        err_nxt     = cfg_err;
        fb_nxt      = fallback;
        retry_nxt   = retry_cnt;
        cur_nxt     = cur_page;
        unique case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (req) begin
                    ok_nxt    = 1'b0;
                    err_nxt   = 1'b0;
                    fb_nxt    = 1'b0;
                    retry_nxt = 3'd0;
                    if (mode_direct && (32'(page_sel) >= NUM_PAGES)) begin
                        err_nxt = 1'b1;
                    end else begin
                        pgm_nxt     = mode_direct ? page_sel : next_page;
                        busy_nxt    = 1'b1;
                        nreconf_nxt = 1'b0;
                        cnt_nxt     = '0;
                        state_nxt   = S_RECONF;
                    end
                end
            end
            S_RECONF: begin
                if (cnt == RECONF_LAST) begin
                    nreconf_nxt = 1'b1;
                    nrst_nxt    = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = S_PFL_RST;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_PFL_RST: begin
                if (cnt == RST_LAST) begin
                    nrst_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (fpga_conf_done_s) begin
                    state_nxt = S_DONE;
                end else if (cnt == WAIT_LAST) begin
                    state_nxt = S_DECIDE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DECIDE: begin
                if (retry_cnt < RETRY_LIMIT) begin
                    retry_nxt   = retry_cnt + 3'd1;
                    nreconf_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = S_RECONF;
                end else if (fpga_pgm != FACTORY) begin
                    pgm_nxt     = FACTORY;
                    fb_nxt      = 1'b1;
                    retry_nxt   = 3'd0;
                    nreconf_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = S_RECONF;
                end else begin
                    state_nxt = S_ERROR;
                end
            end
            S_DONE: begin
                ok_nxt    = 1'b1;
                cur_nxt   = fpga_pgm;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                err_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pfl_cfg_sequencer.sv
// Bench for pfl_cfg_sequencer: directed and randomized requests checked
// against an attempt-level reference model of the configuration sequence.
module tb_pfl_cfg_sequencer;

    localparam int NP      = 3;
    localparam int PW      = 3;
    localparam int RC      = 4;
    localparam int RS      = 3;
    localparam int WC      = 10;
    localparam int MR      = 1;
    localparam int FACTORY = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          max_csn = 1'b1;
    logic          mode_direct = 1'b0;
    logic [PW-1:0] page_sel = '0;
    logic          conf_done = 1'b0;
    logic          statusn = 1'b1;
    logic [PW-1:0] fpga_pgm;
    logic          pfl_nreconfigure, pfl_nreset, busy, cfg_ok, cfg_err, fallback;
    logic [2:0]    retry_cnt;
    logic [PW-1:0] cur_page;

    int total = 0;
    int bad   = 0;
    int m_cur = FACTORY;
    int m_pgm = FACTORY;
    int plan[4];

    always #5 clk = ~clk;

    pfl_cfg_sequencer #(
        .NUM_PAGES(NP), .PAGE_W(PW), .FACTORY_PAGE(FACTORY),
        .RECONF_CYCLES(RC), .RST_CYCLES(RS), .WAIT_CYCLES(WC),
        .MAX_RETRY(MR), .CNT_W(28)
    ) dut (
        .clkin_max_100(clk), .sys_resetn(rst_n), .max_csn(max_csn),
        .mode_direct(mode_direct), .page_sel(page_sel),
        .fpga_conf_done(conf_done), .fpga_statusn(statusn),
        .fpga_pgm(fpga_pgm), .pfl_nreconfigure(pfl_nreconfigure),
        .pfl_nreset(pfl_nreset), .busy(busy), .cfg_ok(cfg_ok),
        .cfg_err(cfg_err), .fallback(fallback), .retry_cnt(retry_cnt),
        .cur_page(cur_page)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_plan(input int a, input int b, input int c, input int d);
        plan[0] = a; plan[1] = b; plan[2] = c; plan[3] = d;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " pgm"}, fpga_pgm, FACTORY);
        chk({tag, " nreconf"}, pfl_nreconfigure, 1);
        chk({tag, " nreset"}, pfl_nreset, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " ok"}, cfg_ok, 0);
        chk({tag, " err"}, cfg_err, 0);
        chk({tag, " fallback"}, fallback, 0);
        chk({tag, " retry"}, retry_cnt, 0);
        chk({tag, " cur"}, cur_page, FACTORY);
    endtask

    // One host request; plan[k] is the WAIT-cycle delay before conf_done on attempt k (-1 = never)
    task automatic run_req(input string tag, input int mode, input int psel, input bit toggle);
        int exp_pages[$];
        int exp_retry[$];
        int exp_fb[$];
        int e_ok, e_err, e_fb, e_r, pg, r, fb, k, stop;
        int n, att, rc_len, rs_len, rs_falls, wcnt, idx;
        bit busy_seen, prev_rc, prev_rs, armed, finished;

        e_ok = 0; e_err = 0; e_fb = 0; e_r = 0;
        if (mode != 0 && psel >= NP) begin
            e_err = 1;
        end else begin
            pg = (mode != 0) ? psel : (m_cur + 1) % NP;
            r = 0; fb = 0; k = 0; stop = 0;
            while (stop == 0) begin
                exp_pages.push_back(pg);
                exp_retry.push_back(r);
                exp_fb.push_back(fb);
                if (plan[k] >= 0) begin
                    e_ok = 1; m_cur = pg; stop = 1;
                end else if (r < MR) begin
                    r++;
                end else if (pg != FACTORY) begin
                    pg = FACTORY; fb = 1; r = 0;
                end else begin
                    e_err = 1; stop = 1;
                end
                k++;
            end
            m_pgm = pg; e_fb = fb; e_r = r;
        end

        max_csn = 1'b1; conf_done = 1'b0; statusn = 1'b1;
        mode_direct = (mode != 0); page_sel = psel[PW-1:0];
        repeat (4) @(posedge clk);
        #1 max_csn = 1'b0;
        n = 0; att = 0; rc_len = 0; rs_len = 0; rs_falls = 0; wcnt = 0;
        busy_seen = 0; prev_rc = 1; prev_rs = 1; armed = 0; finished = 0;
        while (!finished && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_seen = 1;
            if (prev_rc && !pfl_nreconfigure) begin
                if (att < exp_pages.size()) begin
                    chk({tag, " attempt page"}, fpga_pgm, exp_pages[att]);
                    chk({tag, " attempt retry"}, retry_cnt, exp_retry[att]);
                    chk({tag, " attempt fallback"}, fallback, exp_fb[att]);
                end
                att++; conf_done = 1'b0; armed = 0; statusn = 1'b1;
            end
            if (!pfl_nreconfigure) rc_len++;
            else if (!prev_rc) begin
                chk({tag, " reconf width"}, rc_len, RC);
                rc_len = 0;
            end
            if (prev_rs && !pfl_nreset) rs_falls++;
            if (!pfl_nreset) rs_len++;
            else if (!prev_rs) begin
                chk({tag, " nreset width"}, rs_len, RS);
                rs_len = 0; armed = 1; wcnt = 0; statusn = 1'b0;
            end
            if (armed) begin
                idx = att - 1;
                if (idx >= 0 && idx < 4 && plan[idx] >= 0 && wcnt >= plan[idx]) conf_done = 1'b1;
                wcnt++;
            end
            if (toggle && att == 1 && rc_len == 2) max_csn = 1'b1;
            if (toggle && att == 1 && rs_len == 1) max_csn = 1'b0;
            prev_rc = pfl_nreconfigure;
            prev_rs = pfl_nreset;
            finished = busy_seen ? !busy : (n >= 20);
        end
        chk({tag, " completed in budget"}, finished, 1);
        chk({tag, " attempts"}, att, exp_pages.size());
        chk({tag, " nreset pulses"}, rs_falls, exp_pages.size());
        chk({tag, " ok"}, cfg_ok, e_ok);
        chk({tag, " err"}, cfg_err, e_err);
        chk({tag, " fallback"}, fallback, e_fb);
        chk({tag, " retry"}, retry_cnt, e_r);
        chk({tag, " cur"}, cur_page, m_cur);
        chk({tag, " pgm"}, fpga_pgm, m_pgm);
        chk({tag, " busy idle"}, busy, 0);
        conf_done = 1'b0; statusn = 1'b1;
    endtask

    initial begin
        int n;
        #23;
        chk_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_values("after reset");

        set_plan(5, -1, -1, -1);
        run_req("next1", 0, 0, 0);
        set_plan(0, -1, -1, -1);
        run_req("next2", 0, 0, 0);
        set_plan(3, -1, -1, -1);
        run_req("next wrap", 0, 0, 0);
        set_plan(1, -1, -1, -1);
        run_req("next after wrap", 0, 0, 0);

        set_plan(-1, -1, 3, -1);
        run_req("direct2 fallback", 1, 2, 0);

        set_plan(2, -1, -1, -1);
        run_req("next before err", 0, 0, 0);
        set_plan(-1, -1, -1, -1);
        run_req("direct factory err", 1, 0, 0);

        set_plan(0, -1, -1, -1);
        run_req("direct invalid", 1, 5, 0);
        set_plan(4, -1, -1, -1);
        run_req("toggle in reconf", 0, 0, 1);

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 4; j++)
                plan[j] = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 5));
            run_req($sformatf("rand%0d", i), int'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 0);
        end

        // Asynchronous reset while the PFL reset pulse is active
        max_csn = 1'b1; mode_direct = 1'b0;
        repeat (4) @(posedge clk);
        #1 max_csn = 1'b0;
        n = 0;
        while (pfl_nreset !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached pfl_rst", pfl_nreset, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("mid reset");
        max_csn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("idle after reset busy", busy, 0);
        chk("idle after reset nreconf", pfl_nreconfigure, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfl_cfg_sequencer.md
Name: pfl_cfg_sequencer

Overview:
Parametrised FPGA configuration sequencer in the MAX II system CPLD. It drives the PFL pfl_nreconfigure, pfl_nreset and fpga_pgm page-select inputs.
- On a host request (max_csn) it selects a flash page, either the next page in sequence or a directly addressed one.
- It pulses reconfigure, then resets the PFL, then waits for fpga_conf_done.
- On timeout it retries a bounded number of times, then falls back to the factory page.
- It reports status to LEDs and the host.

Parameters:
NUM_PAGES, 3, number of valid flash pages (2..8)
PAGE_W, 3, width of page select (must match PFL fpga_pgm)
FACTORY_PAGE, 0, fallback page index (< NUM_PAGES)
RECONF_CYCLES, 24'hFFFFFF, pfl_nreconfigure low width in clocks (>=1)
RST_CYCLES, 24'hFFFFFF, pfl_nreset low width in clocks (>=1)
WAIT_CYCLES, 28'hFFFFFFF, conf_done timeout in clocks (>=1)
MAX_RETRY, 1, retries of the same page before fallback (0..7)
CNT_W, 28, shared phase counter width (must hold max of the three cycle counts)

Ports:
clkin_max_100  in  1  system clock, 100 MHz
sys_resetn  in  1  asynchronous active-low reset
max_csn  in  1  host request, active low, asynchronous to clock
mode_direct  in  1  1 = load page_sel, 0 = advance to next page
page_sel  in  PAGE_W  direct page index, sampled at request
fpga_conf_done  in  1  FPGA CONF_DONE, asynchronous
fpga_statusn  in  1  FPGA nSTATUS, asynchronous
fpga_pgm  out  PAGE_W  page to PFL
pfl_nreconfigure  out  1  active-low reconfigure pulse
pfl_nreset  out  1  active-low PFL reset
busy  out  1  sequence in progress
cfg_ok  out  1  last sequence completed (sticky)
cfg_err  out  1  last sequence failed, factory included (sticky)
fallback  out  1  current image is the factory fallback
retry_cnt  out  3  retries used in current attempt
cur_page  out  PAGE_W  last successfully configured page

Behaviour:
- Synchronisation: max_csn, fpga_conf_done and fpga_statusn each pass through a 2-flop synchroniser (_s).
- Request: a 1->0 edge of max_csn_s. It is accepted only in IDLE; edges while busy are ignored.
- All outputs are registered.
- Reset values:
  - state = IDLE
  - pfl_nreconfigure = 1, pfl_nreset = 1
  - busy = 0, cfg_ok = 0, cfg_err = 0, fallback = 0
  - retry_cnt = 0, cur_page = FACTORY_PAGE, fpga_pgm = FACTORY_PAGE
  - counter = 0
- Reset mid-sequence aborts immediately to these values.
- IDLE
  - busy = 0. On a request, clear cfg_ok, cfg_err, fallback and retry_cnt, then compute target:
    - mode_direct = 1: target = page_sel. If page_sel >= NUM_PAGES, set cfg_err = 1 and stay in IDLE (no pulses).
    - mode_direct = 0: target = cur_page + 1, wrapping from NUM_PAGES-1 to 0.
  - Load fpga_pgm = target, set busy = 1, go to RECONF.
- RECONF
  - pfl_nreconfigure = 0 for exactly RECONF_CYCLES clocks, starting the clock after the request is detected.
  - Then go to PFL_RST with counter = 0.
- PFL_RST
  - pfl_nreset = 0 for exactly RST_CYCLES clocks, then go to WAIT.
- WAIT
  - Counter runs from 0. conf_done_s = 1 at any cycle: go to DONE.
  - Counter reaches WAIT_CYCLES-1 with conf_done_s = 0: go to DECIDE.
  - fpga_statusn_s = 0 is tolerated (normal during configuration). It is only informational.
- DECIDE (1 cycle)
  - retry_cnt < MAX_RETRY: retry_cnt += 1, keep fpga_pgm, go to RECONF.
  - Otherwise, if fpga_pgm != FACTORY_PAGE: fpga_pgm = FACTORY_PAGE, fallback = 1, retry_cnt = 0, go to RECONF.
  - Otherwise go to ERROR.
- DONE (1 cycle): cfg_ok = 1, cur_page = fpga_pgm, busy = 0, go to IDLE.
- ERROR (1 cycle): cfg_err = 1, busy = 0, cur_page unchanged, go to IDLE.
- fpga_pgm holds its value in IDLE; the PFL keeps the last page selected.
- The counter saturates at no value: it is cleared on every phase entry and compared to N-1.
- conf_done_s already high on entry to WAIT: DONE on the first WAIT cycle.

Test Plan:
Common setup: NUM_PAGES=3, RECONF_CYCLES=4, RST_CYCLES=3, WAIT_CYCLES=10, MAX_RETRY=1.
1. Reset, mode_direct = 0, drop max_csn, raise conf_done 5 clocks into WAIT.
   -> fpga_pgm = 1; pfl_nreconfigure low exactly 4 clocks, then pfl_nreset low exactly 3 clocks; cfg_ok = 1, cur_page = 1, busy = 0.
2. Three further successful next-page requests.
   -> pages 2, 0, 1 (wrap verified).
3. Direct page_sel = 2, conf_done never rises.
   -> two attempts on page 2 (retry_cnt = 1), then fpga_pgm = 0 and fallback = 1.
   -> with conf_done on the fallback attempt: cfg_ok = 1, cur_page = 0.
4. Direct page_sel = 0 (factory), conf_done never rises.
   -> two attempts, then cfg_err = 1, cur_page unchanged.
5. Direct page_sel = 5.
   -> cfg_err = 1 with no pulse on pfl_nreconfigure or pfl_nreset.
   Also toggle max_csn during RECONF -> ignored, sequence unaffected.
6. Assert sys_resetn low during PFL_RST.
   -> all outputs return to reset values asynchronously; pfl_nreset = 1 the same cycle.
